// File: rtl/nap_timer_ctrl_if.sv
// nap_timer_ctrl_if: selector/control inputs and display/alarm outputs of the nap-timer sequencer.
// Carries the pause line only when NAP_PAUSE_EN is defined.
interface nap_timer_ctrl_if;
  logic [3:0] one_sec;
  logic [3:0] ten_sec;
  logic [3:0] one_min;
  logic       completeSetting;
  logic       stop;
`ifdef NAP_PAUSE_EN
  logic       pause;
`endif
  logic       key_en;
  logic [3:0] min_o;
  logic [3:0] sec_tens_o;
  logic [3:0] sec_ones_o;
  logic       running;
  logic       alarm;

`ifdef NAP_PAUSE_EN
  modport master (
    output one_sec, ten_sec, one_min, completeSetting, stop, pause,
    input  key_en, min_o, sec_tens_o, sec_ones_o, running, alarm
  );
  modport slave (
    input  one_sec, ten_sec, one_min, completeSetting, stop, pause,
    output key_en, min_o, sec_tens_o, sec_ones_o, running, alarm
  );
`else
  modport master (
    output one_sec, ten_sec, one_min, completeSetting, stop,
    input  key_en, min_o, sec_tens_o, sec_ones_o, running, alarm
  );
  modport slave (
    input  one_sec, ten_sec, one_min, completeSetting, stop,
    output key_en, min_o, sec_tens_o, sec_ones_o, running, alarm
  );
`endif
endinterface

// File: rtl/nap_timer_ctrl.sv
// nap_timer_ctrl: accumulates keypad duration codes into a BCD M:SS setting, counts it
// down at 1 Hz and then raises the wake alarm for ALARM_SEC seconds.
// Optional feature macro: NAP_PAUSE_EN (adds PAUSE state and the pause input).
module nap_timer_ctrl #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned ALARM_SEC = 10
) (
  input logic             clock,
  input logic             reset,
  nap_timer_ctrl_if.slave bus
);

  localparam int unsigned DW = 4;
  localparam int unsigned TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(CLK_HZ - 1);
  localparam logic [DW-1:0] ASEC_MAX = DW'(ALARM_SEC - 1);

`ifdef NAP_PAUSE_EN
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_ALARM, S_PAUSE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_ALARM} state_t;
`endif

  state_t        state_q, state_d;
  logic [DW-1:0] min_q, tens_q, ones_q;
  logic [DW-1:0] min_d, tens_d, ones_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [DW-1:0] asec_q, asec_d;
  logic          running_q, alarm_q, key_en_q;

  logic          inc_one, inc_ten, inc_min, add_any;
  logic [4:0]    ones_sum, tens_sum, min_sum;
  logic          ones_c, tens_c;
  logic [DW-1:0] sum_min, sum_tens, sum_ones;
  logic [DW-1:0] dec_min, dec_tens, dec_ones;
  logic          dec_zero, tick_wrap, pause_req;

  assign inc_one   = (bus.one_sec == 4'd5);
  assign inc_ten   = (bus.ten_sec == 4'd3);
  assign inc_min   = (bus.one_min == 4'd1);
  assign add_any   = inc_one | inc_ten | inc_min;
  assign tick_wrap = (tick_q == TICK_MAX);
`ifdef NAP_PAUSE_EN
  assign pause_req = bus.pause;
`else
  assign pause_req = 1'b0;
`endif

  // BCD add of this cycle's codes to the current setting, saturating at 9:59
  always_comb begin
    ones_sum = 5'(ones_q) + (inc_one ? 5'd5 : 5'd0);
    ones_c   = (ones_sum >= 5'd10);
    tens_sum = 5'(tens_q) + (inc_ten ? 5'd3 : 5'd0) + 5'(ones_c);
    tens_c   = (tens_sum >= 5'd6);
    min_sum  = 5'(min_q) + (inc_min ? 5'd1 : 5'd0) + 5'(tens_c);
    if (min_sum > 5'd9) begin
      sum_min  = 4'd9;
      sum_tens = 4'd5;
      sum_ones = 4'd9;
    end else begin
      sum_min  = min_sum[3:0];
      sum_tens = tens_c ? 4'(tens_sum - 5'd6) : tens_sum[3:0];
      sum_ones = ones_c ? 4'(ones_sum - 5'd10) : ones_sum[3:0];
    end
  end

  // One-second BCD decrement with borrow chain; flags the step that lands on 0:00
  always_comb begin
    dec_ones = ones_q - 4'd1;
    dec_tens = tens_q;
    dec_min  = min_q;
    if (ones_q == 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
      if (tens_q == 4'd0) begin
        dec_tens = 4'd5;
        dec_min  = min_q - 4'd1;
      end
    end
    dec_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);
  end

  // Next-state, digit, tick and alarm-second logic
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    tick_d  = tick_q;
    asec_d  = asec_q;
    unique case (state_q)
      S_IDLE: begin
        min_d  = '0;
        tens_d = '0;
        ones_d = '0;
        tick_d = '0;
        if (!bus.stop && !bus.completeSetting && add_any) begin
          state_d = S_SETUP;
          min_d   = sum_min;
          tens_d  = sum_tens;
          ones_d  = sum_ones;
        end
      end
      S_SETUP: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          min_d   = '0;
          tens_d  = '0;
          ones_d  = '0;
        end else if (bus.completeSetting) begin
          tick_d  = '0;
          state_d = ((min_q | tens_q | ones_q) != 4'd0) ? S_RUN : S_IDLE;
        end else if (add_any) begin
          min_d  = sum_min;
          tens_d = sum_tens;
          ones_d = sum_ones;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          min_d   = '0;
          tens_d  = '0;
          ones_d  = '0;
          tick_d  = '0;
        end else if (pause_req) begin
`ifdef NAP_PAUSE_EN
          state_d = S_PAUSE;
`endif
        end else if (tick_wrap) begin
          tick_d = '0;
          min_d  = dec_min;
          tens_d = dec_tens;
          ones_d = dec_ones;
          if (dec_zero) begin
            state_d = S_ALARM;
            asec_d  = '0;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_ALARM: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else if (tick_wrap) begin
          tick_d = '0;
          if (asec_q == ASEC_MAX) begin
            state_d = S_IDLE;
          end else begin
            asec_d = asec_q + 4'd1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
`ifdef NAP_PAUSE_EN
      S_PAUSE: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          min_d   = '0;
          tens_d  = '0;
          ones_d  = '0;
          tick_d  = '0;
        end else if (bus.pause) begin
          state_d = S_RUN;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      min_q     <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      tick_q    <= '0;
      asec_q    <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      key_en_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      tick_q    <= tick_d;
      asec_q    <= asec_d;
      running_q <= (state_d == S_RUN);
      alarm_q   <= (state_d == S_ALARM);
      key_en_q  <= (state_d == S_IDLE) || (state_d == S_SETUP);
    end
  end

  assign bus.key_en     = key_en_q;
  assign bus.min_o      = min_q;
  assign bus.sec_tens_o = tens_q;
  assign bus.sec_ones_o = ones_q;
  assign bus.running    = running_q;
  assign bus.alarm      = alarm_q;

endmodule

// File: tb/tb_nap_timer_ctrl.sv
// tb_nap_timer_ctrl: scoreboard bench; the driver pushes the reference model's expected
// outputs per clock, a monitor pops and compares them one step after each rising edge.
module tb_nap_timer_ctrl;

  localparam int HZ   = 4;
  localparam int ASEC = 2;
`ifdef NAP_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_SETUP = 1;
  localparam int M_RUN   = 2;
  localparam int M_ALARM = 3;
  localparam int M_PAUSE = 4;

  typedef struct packed {
    logic       key_en;
    logic [3:0] mn;
    logic [3:0] st;
    logic [3:0] so;
    logic       running;
    logic       alarm;
  } snap_t;

  logic clock;
  logic reset;
  nap_timer_ctrl_if bus();

  nap_timer_ctrl #(.CLK_HZ(HZ), .ALARM_SEC(ASEC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    total = 0;
  int    bad   = 0;
  snap_t exp_q[$];

  // Reference model: remaining time in whole seconds, cycles spent in the current timed mode
  int m_mode = M_IDLE;
  int m_rem  = 0;
  int m_cyc  = 0;

  function automatic snap_t model_out();
    snap_t s;
    s.key_en  = (m_mode == M_IDLE) || (m_mode == M_SETUP);
    s.mn      = 4'(m_rem / 60);
    s.st      = 4'((m_rem % 60) / 10);
    s.so      = 4'(m_rem % 10);
    s.running = (m_mode == M_RUN);
    s.alarm   = (m_mode == M_ALARM);
    return s;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_rem  = 0;
    m_cyc  = 0;
  endfunction

  function automatic void model_step(input logic [3:0] os, input logic [3:0] ts,
                                     input logic [3:0] om, input logic cs,
                                     input logic sp, input logic ps);
    int add;
    add = ((os == 4'd5) ? 5 : 0) + ((ts == 4'd3) ? 30 : 0) + ((om == 4'd1) ? 60 : 0);
    case (m_mode)
      M_IDLE: begin
        if (!sp && !cs && add > 0) begin
          m_rem  = (add > 599) ? 599 : add;
          m_mode = M_SETUP;
        end
      end
      M_SETUP: begin
        if (sp) begin
          m_mode = M_IDLE;
          m_rem  = 0;
        end else if (cs) begin
          m_cyc  = 0;
          m_mode = (m_rem > 0) ? M_RUN : M_IDLE;
        end else begin
          m_rem = (m_rem + add > 599) ? 599 : m_rem + add;
        end
      end
      M_RUN: begin
        if (sp) begin
          m_mode = M_IDLE;
          m_rem  = 0;
        end else if (PAUSE_EN && ps) begin
          m_mode = M_PAUSE;
        end else begin
          m_cyc++;
          if (m_cyc % HZ == 0) begin
            m_rem--;
            if (m_rem == 0) begin
              m_mode = M_ALARM;
              m_cyc  = 0;
            end
          end
        end
      end
      M_ALARM: begin
        if (sp) begin
          m_mode = M_IDLE;
        end else begin
          m_cyc++;
          if (m_cyc == HZ * ASEC) m_mode = M_IDLE;
        end
      end
      default: begin
        if (sp) begin
          m_mode = M_IDLE;
          m_rem  = 0;
        end else if (ps) begin
          m_mode = M_RUN;
        end
      end
    endcase
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.key_en  = bus.key_en;
    s.mn      = bus.min_o;
    s.st      = bus.sec_tens_o;
    s.so      = bus.sec_ones_o;
    s.running = bus.running;
    s.alarm   = bus.alarm;
    return s;
  endfunction

  task automatic check(input string name, input snap_t got, input snap_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got key_en=%b %0d:%0d%0d run=%b alarm=%b, expected key_en=%b %0d:%0d%0d run=%b alarm=%b",
               name, $time, got.key_en, got.mn, got.st, got.so, got.running, got.alarm,
               exp.key_en, exp.mn, exp.st, exp.so, exp.running, exp.alarm);
    end
  endtask

  // Monitor: registered outputs settle after each rising edge
  initial begin
    snap_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", dut_snap(), e);
      end
    end
  end

  task automatic drive(input logic [3:0] os, input logic [3:0] ts, input logic [3:0] om,
                       input logic cs, input logic sp, input logic ps);
    @(negedge clock);
    bus.one_sec         = os;
    bus.ten_sec         = ts;
    bus.one_min         = om;
    bus.completeSetting = cs;
    bus.stop            = sp;
`ifdef NAP_PAUSE_EN
    bus.pause           = ps;
`endif
    model_step(os, ts, om, cs, sp, ps);
    exp_q.push_back(model_out());
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock
  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    bus.one_sec = 4'd0; bus.ten_sec = 4'd0; bus.one_min = 4'd0;
    bus.completeSetting = 1'b0; bus.stop = 1'b0;
`ifdef NAP_PAUSE_EN
    bus.pause = 1'b0;
`endif
    model_reset();
    #1;
    check("async_reset", dut_snap(), model_out());
    exp_q.push_back(model_out());
    for (int i = 1; i < n; i++) begin
      @(negedge clock);
      exp_q.push_back(model_out());
    end
    @(negedge clock);
    reset = 1'b0;
    exp_q.push_back(model_out());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] os, ts, om;
    logic       cs, sp, ps;
    reset = 1'b1;
    bus.one_sec = 4'd0; bus.ten_sec = 4'd0; bus.one_min = 4'd0;
    bus.completeSetting = 1'b0; bus.stop = 1'b0;
`ifdef NAP_PAUSE_EN
    bus.pause = 1'b0;
`endif
    do_reset(3);
    quiet(2);

    // 0:05 countdown into alarm and back to idle
    drive(4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    quiet(20 + 8 + 2);

    // 2:00 with full borrow chain to 1:59, then stop
    drive(4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    quiet(6);
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    quiet(2);

    // Saturation at 9:59, unrecognised codes, multiple adds in one cycle
    for (int i = 0; i < 12; i++) drive(4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    drive(4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    drive(4'd4, 4'd2, 4'd7, 1'b0, 1'b0, 1'b0);
    drive(4'd5, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0);
    drive(4'd5, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);

    // completeSetting with nothing set stays idle
    drive(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    quiet(2);

    // stop mid-run at 0:03
    drive(4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    quiet(8);
    drive(4'd5, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0);
    quiet(2);

    // reset pulse in the middle of the alarm
    drive(4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    quiet(23);
    do_reset(1);
    quiet(2);

`ifdef NAP_PAUSE_EN
    // pause at 0:04 after 2 counted cycles, hold, resume
    drive(4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    quiet(6);
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    quiet(10);
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    quiet(3);
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    quiet(2);
`endif

    // Randomised traffic, including ignored and unrecognised codes
    for (int i = 0; i < 3000; i++) begin
      os = ($urandom_range(0, 99) < 15) ? 4'd5 : (($urandom_range(0, 99) < 5) ? 4'(($urandom_range(0, 15))) : 4'd0);
      ts = ($urandom_range(0, 99) < 12) ? 4'd3 : (($urandom_range(0, 99) < 5) ? 4'(($urandom_range(0, 15))) : 4'd0);
      om = ($urandom_range(0, 99) < 8)  ? 4'd1 : (($urandom_range(0, 99) < 5) ? 4'(($urandom_range(0, 15))) : 4'd0);
      cs = ($urandom_range(0, 99) < 6);
      sp = ($urandom_range(0, 199) < 3);
      ps = ($urandom_range(0, 99) < 3);
      drive(os, ts, om, cs, sp, ps);
    end
    quiet(2);

    @(posedge clock);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
